// File: rtl/rr_arb_4.sv
// Four-channel round-robin arbiter with a one-entry registered output stage.
// Define RR_ARB_4_CNT_EN to add the saturating output-transfer counter xfer_cnt.
module rr_arb_4 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] vld,
   output logic [3:0] rdy,
   output logic [3:0] y,
   output logic [1:0] y_sel,
   output logic       y_vld,
   input  logic       y_rdy
`ifdef RR_ARB_4_CNT_EN
   ,
   output logic [7:0] xfer_cnt
`endif
);

   localparam int unsigned DW  = 4;
   localparam int unsigned NCH = 4;
   localparam int unsigned IW  = 2;
`ifdef RR_ARB_4_CNT_EN
   localparam int unsigned CW  = 8;
`endif

   logic [IW-1:0] last;
   logic [IW-1:0] scan_idx;
   logic [IW-1:0] gnt_idx;
   logic          gnt_any;
   logic          load_ok;
   logic          src_xfer;
   logic [DW-1:0] d_sel;

   // Scan from last+4 (== last) down to last+1 so the nearest valid channel after last wins.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = last;
      scan_idx = last;
      for (int unsigned k = NCH; k > 0; k--) begin
         scan_idx = last + IW'(k);
         if (vld[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
   end

   // No grant is offered while reset is held, so rdy clears together with the state.
   always_comb begin
      load_ok  = !y_vld || y_rdy;
      src_xfer = rst_n && load_ok && gnt_any;
      rdy      = src_xfer ? (NCH'(1) << gnt_idx) : '0;
   end

   // Mux is steered only by the grant, so data on non-granted channels never reaches y.
   always_comb begin
      d_sel = d0;
      case (gnt_idx)
         2'd0:    d_sel = d0;
         2'd1:    d_sel = d1;
         2'd2:    d_sel = d2;
         default: d_sel = d3;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y     <= '0;
         y_sel <= '0;
         y_vld <= 1'b0;
         last  <= IW'(NCH - 1);
      end else if (src_xfer) begin
         y     <= d_sel;
         y_sel <= gnt_idx;
         y_vld <= 1'b1;
         last  <= gnt_idx;
      end else if (y_vld && y_rdy) begin
         y_vld <= 1'b0;
      end
   end

`ifdef RR_ARB_4_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (y_vld && y_rdy && (xfer_cnt != {CW{1'b1}})) begin
         xfer_cnt <= xfer_cnt + CW'(1);
      end
   end
`endif

endmodule

// File: doc/rr_arb_4.md
# rr_arb_4

Four-channel round-robin arbiter with a one-entry registered output; it sits directly upstream of the 4:1 4-bit data mux stage. Each cycle it selects one of four valid/ready source channels and captures that channel's 4-bit word together with the 2-bit select index. Downstream logic receives both the captured word and the select index for steering or checking. Arbitration is fair round-robin, and the output is fully registered.

## Interface
- No parameters. Data width is fixed at 4 bits and channel count is fixed at 4.
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous assert and active-low
- d0, d1, d2, d3  input  4 each  channel data words
- vld  input  4  per-channel valid; bit i belongs to d<i>
- rdy  output  4  per-channel ready; at most one bit high (one-hot or zero)
- y  output  4  registered selected data
- y_sel  output  2  registered index of the channel that produced y
- y_vld  output  1  output entry valid
- y_rdy  input  1  downstream ready
- xfer_cnt  output  8  accepted output transfers; present only with RR_ARB_4_CNT_EN

## Operation
- State:
  - output entry holding y, y_sel and y_vld
  - 2-bit pointer `last` holding the most recently granted index
- Reset values: y=0, y_sel=0, y_vld=0, last=3 (so channel 0 has first priority), xfer_cnt=0.
- Load condition: `load_ok` = !y_vld || y_rdy.
- Arbitration is combinational:
  - Scan channels in order last+1, last+2, last+3, last (modulo 4).
  - The first index g with vld[g]=1 wins.
- Grant:
  - rdy[g] = load_ok && vld[g] for the winner g.
  - All other rdy bits are 0.
  - If no channel is valid or load_ok=0, rdy=0.
- Source transfer: occurs on channel i when vld[i] && rdy[i]. On that edge:
  - y ← d[i]
  - y_sel ← i
  - y_vld ← 1
  - last ← i
- Output transfer: occurs when y_vld && y_rdy. If no source transfer happens in the same cycle, y_vld ← 0.
- Simultaneous output and source transfer: the entry is replaced and y_vld stays 1, giving full throughput with no bubble.
- Stall (y_vld=1, y_rdy=0):
  - y, y_sel and y_vld hold.
  - rdy=0.
  - last holds.
- `last` changes only on a source transfer. Idle cycles do not rotate priority.
- Values on d<i> are don't-care when vld[i]=0. X on a non-granted channel must not propagate to y.
- rdy[i] may depend combinationally on vld and y_rdy. It never depends on d<i>.

## Timing
- Latency: a word accepted at edge N appears on y/y_sel with y_vld=1 after edge N.
- Throughput: one word per cycle when y_rdy is held high and any vld bit is set.
- Combinational path y_rdy → rdy is permitted. No combinational path exists from any input to y, y_sel or y_vld.
- Reset deasserted mid-stream:
  - Asserting rst_n low clears all state immediately, with no clock required.
  - After release, the first grant goes to the lowest-index valid channel.
- Sources must keep vld[i] and d<i> stable until accepted. The bench checks this; the block does not.

## Configuration
- RR_ARB_4_CNT_EN defined:
  - Adds output xfer_cnt[7:0].
  - Increments on each output transfer (y_vld && y_rdy).
  - Saturates at 255.
  - Resets to 0 asynchronously with rst_n.
- RR_ARB_4_CNT_EN undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then all channels idle with y_rdy=1:
  - y=0, y_sel=0, y_vld=0 and rdy=4'b0000 for 5 cycles.
- d0..d3 = a, b, c, d, vld=4'b1111 held, y_rdy=1:
  - Outputs on consecutive cycles are (y, y_sel) = (a,0), (b,1), (c,2), (d,3), (a,0).
  - y_vld stays 1 after the first cycle.
- vld=4'b0101 with d0=7, d2=3; y_rdy low for 3 cycles after the first capture:
  - y=7, y_sel=0 holds for those 3 cycles with rdy=0.
  - After y_rdy rises, the next capture is y=3, y_sel=2.
- last=1, then only vld[1] asserted:
  - Channel 1 is granted again.
  - d3=x while vld[3]=0 never appears on y.
- Assert rst_n=0 mid-stream between clock edges while y_vld=1:
  - y_vld, y, y_sel and rdy go to 0 immediately.
  - After release with vld=4'b1000, y_sel=3.
- With RR_ARB_4_CNT_EN and 300 back-to-back output transfers:
  - xfer_cnt reads 255.
  - Without the macro, the design elaborates with no xfer_cnt port.
